channel_reader: RTL and testbench

CHANNEL_READER -- requirements
Module: channel_reader

---
 rtl/channel_reader.sv | 162 ++++++++++++++++
 tb/tb_channel_reader.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/channel_reader.sv
// channel_reader: drains a bank of event-logger channels onto a byte-wide
// host link. Each frame is a header byte and, unless the channel reported an
// overrun, eight data bytes read through the shared byteaddr select. A frame
// ends with a single-cycle unload (data frame) or clearoverrun (overrun frame)
// pulse. A holdoff period follows, after which channels are scanned round-robin.
module channel_reader #(
    parameter int NCH     = 4,
    parameter int HOLDOFF = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NCH-1:0]   attention,
    input  logic [NCH-1:0]   overrun,
    input  logic [8*NCH-1:0] chdata,
    output logic [2:0]       byteaddr,
    output logic [NCH-1:0]   unload,
    output logic [NCH-1:0]   clearoverrun,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] HDR  = 3'd1;
    localparam logic [2:0] SEL  = 3'd2;
    localparam logic [2:0] DATA = 3'd3;
    localparam logic [2:0] POP  = 3'd4;
    localparam logic [2:0] HOLD = 3'd5;

    logic [2:0] state_r;
    logic [3:0] ch_r;
    logic       ovf_r;
    logic [3:0] last_r;
    logic [3:0] hold_cnt_r;

    logic       hi_found_s;
    logic [3:0] hi_pick_s;
    logic [3:0] lo_pick_s;
    logic [3:0] pick_s;
    logic       pick_ovr_s;
    logic [7:0] sel_data_s;

    // One-hot strobe vector for the channel being served.
    function automatic logic [NCH-1:0] onehot(input logic [3:0] idx);
        logic [NCH-1:0] r;
        r = '0;
        for (int i = 0; i < NCH; i++) begin
            r[i] = (4'(i) == idx);
        end
        return r;
    endfunction

    // Round-robin pick: lowest requester above the last served channel,
    // otherwise wrap to the lowest requester overall.
    always_comb begin
        hi_found_s = 1'b0;
        hi_pick_s  = 4'd0;
        lo_pick_s  = 4'd0;
        for (int i = NCH - 1; i >= 0; i--) begin
            lo_pick_s  = attention[i] ? 4'(i) : lo_pick_s;
            hi_pick_s  = (attention[i] && (4'(i) > last_r)) ? 4'(i) : hi_pick_s;
            hi_found_s = hi_found_s | (attention[i] && (4'(i) > last_r));
        end
        pick_s = hi_found_s ? hi_pick_s : lo_pick_s;
    end

    // Per-channel muxes: overrun flag of the candidate and data of the served channel.
    always_comb begin
        pick_ovr_s = 1'b0;
        sel_data_s = 8'h00;
        for (int i = 0; i < NCH; i++) begin
            pick_ovr_s = (4'(i) == pick_s) ? overrun[i] : pick_ovr_s;
            sel_data_s = (4'(i) == ch_r) ? chdata[8*i +: 8] : sel_data_s;
        end
    end

    // Frame sequencer; every output is registered and strobes default low.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            ch_r         <= 4'd0;
            ovf_r        <= 1'b0;
            last_r       <= 4'(NCH - 1);
            hold_cnt_r   <= 4'd0;
            byteaddr     <= 3'd0;
            unload       <= '0;
            clearoverrun <= '0;
            tx_data      <= 8'h00;
            tx_valid     <= 1'b0;
        end else begin
            unload       <= '0;
            clearoverrun <= '0;
            case (state_r)
                IDLE: begin
                    if (|attention) begin
                        ch_r     <= pick_s;
                        ovf_r    <= pick_ovr_s;
                        tx_data  <= {1'b1, pick_ovr_s, 2'b00, pick_s};
                        tx_valid <= 1'b1;
                        state_r  <= HDR;
                    end else begin
                        state_r  <= IDLE;
                    end
                end
                HDR: begin
                    if (tx_ready) begin
                        tx_valid <= 1'b0;
                        if (ovf_r) begin
                            // Overrun frame is the header alone.
                            clearoverrun <= onehot(ch_r);
                            hold_cnt_r   <= 4'd0;
                            state_r      <= HOLD;
                        end else begin
                            byteaddr <= 3'd0;
                            state_r  <= SEL;
                        end
                    end else begin
                        state_r <= HDR;
                    end
                end
                SEL: begin
                    // chdata has had a full cycle to settle on the new byteaddr.
                    tx_data  <= sel_data_s;
                    tx_valid <= 1'b1;
                    state_r  <= DATA;
                end
                DATA: begin
                    if (tx_ready) begin
                        tx_valid <= 1'b0;
                        if (byteaddr == 3'd7) begin
                            unload  <= onehot(ch_r);
                            state_r <= POP;
                        end else begin
                            byteaddr <= byteaddr + 3'd1;
                            state_r  <= SEL;
                        end
                    end else begin
                        state_r <= DATA;
                    end
                end
                POP: begin
                    hold_cnt_r <= 4'd0;
                    state_r    <= HOLD;
                end
                HOLD: begin
                    // Give the channel time to update attention after the pop/clear.
                    if (hold_cnt_r == 4'(HOLDOFF - 1)) begin
                        last_r  <= ch_r;
                        state_r <= IDLE;
                    end else begin
                        hold_cnt_r <= hold_cnt_r + 4'd1;
                    end
                end
                default: begin
                    tx_valid <= 1'b0;
                    state_r  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_channel_reader.sv
// Testbench for channel_reader: table of single-frame vectors plus hand-written
// sequences for round-robin under full load, reset mid-frame and long stalls.
module tb_channel_reader;

    localparam int NCH     = 4;
    localparam int HOLDOFF = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NCH-1:0]   attention = '0;
    logic [NCH-1:0]   overrun = '0;
    logic [8*NCH-1:0] chdata;
    logic [2:0]       byteaddr;
    logic [NCH-1:0]   unload;
    logic [NCH-1:0]   clearoverrun;
    logic [7:0]       tx_data;
    logic             tx_valid;
    logic             tx_ready = 1'b1;

    int errors = 0;
    int checks = 0;

    logic [7:0]     rx_q[$];
    logic [NCH-1:0] unl_q[$];
    logic [NCH-1:0] clr_q[$];
    logic           prev_stall = 1'b0;
    logic [7:0]     prev_data = 8'h00;

    typedef struct {
        logic [3:0] att;
        logic [3:0] ovr;
        bit         toggle;
        logic [7:0] hdr;
        int         ndata;
        logic [3:0] unl;
        logic [3:0] clr;
    } vec_t;

    vec_t vecs[8];

    channel_reader #(.NCH(NCH), .HOLDOFF(HOLDOFF)) dut (
        .clk(clk), .rst(rst), .attention(attention), .overrun(overrun),
        .chdata(chdata), .byteaddr(byteaddr), .unload(unload),
        .clearoverrun(clearoverrun), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready)
    );

    always #5 clk = ~clk;

    // Channel i presents byte 8'h10*i + byteaddr.
    for (genvar g = 0; g < NCH; g++) begin : g_dat
        assign chdata[8*g +: 8] = 8'(16 * g) + {5'd0, byteaddr};
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Link monitor: records transfers and strobes, checks stall stability and strobe exclusivity.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall)
                check("stall_hold", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, prev_data});
            if (tx_valid && tx_ready) rx_q.push_back(tx_data);
            if (unload != '0 || clearoverrun != '0)
                check("pulse_onehot", 32'($countones(unload) + $countones(clearoverrun)), 32'd1);
            if (unload != '0) unl_q.push_back(unload);
            if (clearoverrun != '0) clr_q.push_back(clearoverrun);
            prev_stall <= tx_valid && !tx_ready;
            prev_data  <= tx_data;
        end
    end

    task automatic clear_logs();
        rx_q.delete();
        unl_q.delete();
        clr_q.delete();
    endtask

    task automatic check_data(input int base, input int ch, input string name);
        for (int k = 1; k <= 8; k++) begin
            if (base + k < rx_q.size())
                check(name, 32'(rx_q[base + k]), 32'(16 * ch + k - 1));
            else
                check(name, 32'hFFFF_FFFF, 32'(16 * ch + k - 1));
        end
    endtask

    task automatic do_frame(input vec_t v);
        int ch;
        ch = int'(v.hdr[3:0]);
        clear_logs();
        attention = v.att;
        overrun   = v.ovr;
        for (int c = 0; c < 400 && unl_q.size() == 0 && clr_q.size() == 0; c++) begin
            @(posedge clk); #1;
            tx_ready = v.toggle ? ((c % 4 == 0) || (c % 4 == 3)) : 1'b1;
        end
        check("frame_done", 32'(unl_q.size() + clr_q.size()), 32'd1);
        attention = '0;
        overrun   = '0;
        tx_ready  = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check("header", (rx_q.size() > 0) ? 32'(rx_q[0]) : 32'hFFFF_FFFF, 32'(v.hdr));
        check("nbytes", 32'(rx_q.size()), 32'(1 + v.ndata));
        if (v.ndata > 0) check_data(0, ch, "data");
        check("unload", (unl_q.size() > 0) ? 32'(unl_q[0]) : 32'd0, 32'(v.unl));
        check("unload_cnt", 32'(unl_q.size()), (v.unl != 4'd0) ? 32'd1 : 32'd0);
        check("clear", (clr_q.size() > 0) ? 32'(clr_q[0]) : 32'd0, 32'(v.clr));
        check("clear_cnt", 32'(clr_q.size()), (v.clr != 4'd0) ? 32'd1 : 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //             att      ovr      tgl   hdr    n  unl      clr
        vecs[0] = '{4'b0010, 4'b0000, 1'b0, 8'h81, 8, 4'b0010, 4'b0000};
        vecs[1] = '{4'b0001, 4'b0001, 1'b0, 8'hC0, 0, 4'b0000, 4'b0001};
        vecs[2] = '{4'b1010, 4'b0000, 1'b0, 8'h81, 8, 4'b0010, 4'b0000};
        vecs[3] = '{4'b1010, 4'b0000, 1'b0, 8'h83, 8, 4'b1000, 4'b0000};
        vecs[4] = '{4'b0101, 4'b0100, 1'b0, 8'h80, 8, 4'b0001, 4'b0000};
        vecs[5] = '{4'b0101, 4'b0100, 1'b0, 8'hC2, 0, 4'b0000, 4'b0100};
        vecs[6] = '{4'b0100, 4'b0000, 1'b0, 8'h82, 8, 4'b0100, 4'b0000};
        vecs[7] = '{4'b0010, 4'b0000, 1'b1, 8'h81, 8, 4'b0010, 4'b0000};

        // Reset state.
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_byteaddr", 32'(byteaddr), 32'd0);
        check("rst_unload", 32'(unload), 32'd0);
        check("rst_clear", 32'(clearoverrun), 32'd0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) do_frame(vecs[i]);

        // Reset after the third data byte abandons the frame without an unload.
        clear_logs();
        attention = 4'b0100;
        for (int c = 0; c < 200 && rx_q.size() < 4; c++) begin
            @(posedge clk); #1;
        end
        check("rstmid_progress", 32'(rx_q.size()), 32'd4);
        rst = 1'b1;
        attention = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rstmid_valid", 32'(tx_valid), 32'd0);
        check("rstmid_unload", 32'(unload), 32'd0);
        rst = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        check("rstmid_no_unload", 32'(unl_q.size()), 32'd0);
        check("rstmid_no_bytes", 32'(rx_q.size()), 32'd4);

        // All channels requesting: strict round-robin from channel 0.
        clear_logs();
        attention = 4'b1111;
        for (int c = 0; c < 600 && unl_q.size() < 5; c++) begin
            @(posedge clk); #1;
        end
        attention = '0;
        repeat (12) @(posedge clk);
        #1;
        check("rr_unloads", 32'(unl_q.size()), 32'd5);
        check("rr_bytes", 32'(rx_q.size()), 32'd45);
        for (int f = 0; f < 5; f++) begin
            check("rr_header", (9 * f < rx_q.size()) ? 32'(rx_q[9 * f]) : 32'hFFFF_FFFF,
                  32'(8'h80 + 8'(f % 4)));
            check("rr_unload", (f < unl_q.size()) ? 32'(unl_q[f]) : 32'd0, 32'(1 << (f % 4)));
            check_data(9 * f, f % 4, "rr_data");
        end

        // Long stall with overrun rising and attention dropping mid-frame.
        clear_logs();
        tx_ready  = 1'b0;
        attention = 4'b0010;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (c == 20) begin
                overrun   = 4'b0010;
                attention = 4'b0000;
            end
        end
        check("stall_valid", 32'(tx_valid), 32'd1);
        check("stall_hdr", 32'(tx_data), 32'h81);
        check("stall_no_unload", 32'(unl_q.size()), 32'd0);
        check("stall_no_clear", 32'(clr_q.size()), 32'd0);
        check("stall_no_xfer", 32'(rx_q.size()), 32'd0);
        tx_ready = 1'b1;
        for (int c = 0; c < 200 && unl_q.size() == 0; c++) begin
            @(posedge clk); #1;
        end
        overrun = '0;
        repeat (12) @(posedge clk);
        #1;
        check("stall_bytes", 32'(rx_q.size()), 32'd9);
        check("stall_unload", (unl_q.size() > 0) ? 32'(unl_q[0]) : 32'd0, 32'h2);
        check("stall_clear_cnt", 32'(clr_q.size()), 32'd0);
        check_data(0, 1, "stall_data");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
